spi_master_core: RTL
====================

Name: spi_master_core

Overview:
- Serial master for the team's SPI subsystem; drives SCLK, MOSI and active-low slave selects toward the existing SPI slave model, and captures MISO.
- Host side is a simple go/busy/done handshake with parallel transmit and receive words up to 128 bits.
- Serves as the transmitting end in SPI bus-level benches.
- Runs entirely in the system clock domain; SCLK is generated by a programmable divider.

Parameters:
- DATA_W, 128, maximum character length in bits; width of tx_data_i and rx_data_o.
- LEN_W, 7, width of char_len_i; value 0 means DATA_W bits.
- DIV_W, 16, width of divider_i.

Ports:
- wb_clk_i  input  1  system clock; the only clock.
- wb_rst_i  input  1  reset, synchronous, active-high.
- go_i  input  1  start pulse; accepted only in IDLE.
- divider_i  input  DIV_W  SCLK half-period, in wb_clk_i cycles, minus 1.
- char_len_i  input  LEN_W  bits per transfer; 0 means DATA_W.
- tx_data_i  input  DATA_W  word to transmit.
- ss_sel_i  input  `SPI_SS_NB  slave-select mask; a 1 selects that slave.
- lsb_i  input  1  1 = LSB first, 0 = MSB first.
- tx_negedge_i  input  1  1 = MOSI advances after falling SCLK, 0 = after rising SCLK.
- rx_negedge_i  input  1  1 = MISO sampled on falling SCLK, 0 = on rising SCLK.
- miso_pad_i  input  1  serial data from the slave.
- busy_o  output  1  transfer in progress.
- done_o  output  1  one-cycle completion pulse.
- rx_data_o  output  DATA_W  received word.
- sclk_pad_o  output  1  serial clock; idles low.
- mosi_pad_o  output  1  serial data to the slave.
- ss_pad_o  output  `SPI_SS_NB  slave selects, active low.

Behaviour:
- Reset (wb_rst_i sampled high, including mid-transfer), effective the next edge:
  - sclk_pad_o=0, mosi_pad_o=0, ss_pad_o all ones.
  - busy_o=0, done_o=0, rx_data_o=0.
  - State IDLE; divider and bit counters cleared.
- States: IDLE, SHIFT, DONE.
- IDLE, go_i=1: latch tx_data_i, char_len_i (N), divider_i (D), lsb_i, tx_negedge_i, rx_negedge_i, ss_sel_i. Next cycle:
  - busy_o=1.
  - ss_pad_o = ~latched ss_sel.
  - mosi_pad_o = first bit: tx[N-1] when MSB first, tx[0] when LSB first.
  - Enter SHIFT.
- go_i outside IDLE is ignored. Input changes after the go cycle have no effect on the current transfer.
- SHIFT: SCLK toggles every D+1 cycles, first toggle rising. Exactly N rising and N falling edges.
- MOSI advance:
  - tx_negedge=1: next bit is driven in the cycle of each falling edge except the last.
  - tx_negedge=0: next bit is driven on each rising edge except the first, so each bit stays valid across the rising edge that samples it.
- MISO sampling: miso_pad_i is captured in the cycle the selected edge is generated.
- Receive alignment:
  - MSB first: first received bit lands in rx bit N-1.
  - LSB first: first received bit lands in bit 0.
  - Bits N..DATA_W-1 are 0.
- End of transfer: after the Nth falling edge, go to DONE. In that cycle:
  - rx_data_o updated.
  - done_o=1 for exactly one cycle.
  - busy_o=0.
  - ss_pad_o returns to all ones.
  - sclk_pad_o=0 and mosi_pad_o=0.
  - Next state IDLE.
- A go_i coinciding with the done_o cycle is ignored. go_i is accepted from the following cycle.
- Transfer length: busy_o high for exactly 2*N*(D+1) cycles.
- rx_data_o holds its value until the next completion or reset.
- D=0 gives SCLK = wb_clk_i/2. D is at most 2^DIV_W-1; no overflow handling is needed beyond counter width.
- ss_sel_i=0 is legal: the transfer runs with no slave selected.

Optional Feature:
- Macro: SPI_MASTER_LOOPBACK_EN.
- Defined: adds input port loop_i (1 bit). When loop_i=1, the receive path samples the internal MOSI bit instead of miso_pad_i; pads behave normally.
- Undefined: no loop_i port; receive always uses miso_pad_i.

Test Plan:
- D=0, N=8, tx=0xA5, MSB first, tx_negedge=1, rx_negedge=0, miso_pad_i wired to mosi_pad_o:
  - rx_data_o=0xA5 and exactly 8 SCLK periods of 2 cycles each.
  - busy_o high 16 cycles and done_o pulses once.
- D=3, char_len=0, tx=128'h0123...CDEF, loopback enabled with loop_i=1:
  - rx_data_o equals tx and busy_o high 1024 cycles.
- lsb_i=1, N=4, tx=0x3, miso_pad_i held 1:
  - mosi_pad_o sequence 1,1,0,0 and rx_data_o=0xF with upper bits 0.
- ss_sel_i=8'h04:
  - ss_pad_o=8'hFB throughout busy, 8'hFF in IDLE and in the done cycle.
- go_i pulsed mid-transfer with a different tx_data:
  - Ignored; current transfer completes unchanged and produces a single done_o.
- wb_rst_i asserted after the 3rd rising edge:
  - Next cycle all outputs are at reset values.
  - A new go then completes a full normal transfer.

Source files
------------

// File: rtl/spi_master_core.sv
// -----------------------------------------------------------------------------
// spi_master_core
//
// Serial master for the SPI subsystem. A single go pulse in IDLE latches the
// transfer configuration and the transmit word, then N bits are shifted out on
// mosi_pad_o while miso_pad_i is captured into rx_data_o. SCLK is derived from
// wb_clk_i by a programmable divider and idles low.
//
// Ports:
//   wb_clk_i      system clock (only clock)
//   wb_rst_i      synchronous active-high reset
//   go_i          start pulse, accepted only while idle
//   divider_i     SCLK half-period in wb_clk_i cycles, minus one
//   char_len_i    bits per transfer, 0 selects DATA_W bits
//   tx_data_i     word to transmit
//   ss_sel_i      slave-select mask (1 selects a slave)
//   lsb_i         1 = LSB first, 0 = MSB first
//   tx_negedge_i  1 = MOSI advances after falling SCLK, 0 = after rising SCLK
//   rx_negedge_i  1 = MISO sampled on falling SCLK, 0 = on rising SCLK
//   loop_i        (only with SPI_MASTER_LOOPBACK_EN) receive from internal MOSI
//   miso_pad_i    serial data from the slave
//   busy_o        transfer in progress
//   done_o        one-cycle completion pulse
//   rx_data_o     received word, held until next completion or reset
//   sclk_pad_o    serial clock
//   mosi_pad_o    serial data to the slave
//   ss_pad_o      active-low slave selects
//
// Build option: define SPI_MASTER_LOOPBACK_EN to add the loop_i port.
// -----------------------------------------------------------------------------

`ifndef SPI_SS_NB
`define SPI_SS_NB 8
`endif

module spi_master_core #(
    parameter int DATA_W = 128,
    parameter int LEN_W  = 7,
    parameter int DIV_W  = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  go_i,
    input  logic [DIV_W-1:0]      divider_i,
    input  logic [LEN_W-1:0]      char_len_i,
    input  logic [DATA_W-1:0]     tx_data_i,
    input  logic [`SPI_SS_NB-1:0] ss_sel_i,
    input  logic                  lsb_i,
    input  logic                  tx_negedge_i,
    input  logic                  rx_negedge_i,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic                  loop_i,
`endif
    input  logic                  miso_pad_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_W-1:0]     rx_data_o,
    output logic                  sclk_pad_o,
    output logic                  mosi_pad_o,
    output logic [`SPI_SS_NB-1:0] ss_pad_o
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam int N_W   = LEN_W + 1;   // holds N up to DATA_W
    localparam int CNT_W = LEN_W + 2;   // holds 2*N SCLK edges

    localparam logic [N_W-1:0] N_MAX = N_W'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_reg, state_next;

    logic [DATA_W-1:0]       tx_reg;
    logic [DATA_W-1:0]       rx_shift_reg;
    logic [DATA_W-1:0]       rx_shift_next;
    logic [DATA_W-1:0]       rx_data_reg;
    logic [N_W-1:0]          n_reg;
    logic [DIV_W-1:0]        div_reg;
    logic                    lsb_reg;
    logic                    tx_neg_reg;
    logic                    rx_neg_reg;
    logic [`SPI_SS_NB-1:0]   ss_sel_reg;
    logic [DIV_W-1:0]        div_cnt_reg;
    logic [CNT_W-1:0]        edge_cnt_reg;
    logic                    sclk_reg;
    logic [IDX_W-1:0]        tx_idx_reg;
    logic [IDX_W-1:0]        rx_idx_reg;

    // Configuration decode for the go cycle
    logic [N_W-1:0]          go_n;
    logic [IDX_W-1:0]        go_first_idx;

    // Per-cycle SCLK event decode
    logic [CNT_W-1:0]        two_n;
    logic                    tick;
    logic                    rise_tick;
    logic                    fall_tick;
    logic                    first_rise;
    logic                    last_tick;
    logic                    tx_adv;
    logic                    sample;
    logic                    mosi_bit;
    logic                    rx_in;
    logic [IDX_W-1:0]        tx_idx_step;
    logic [IDX_W-1:0]        rx_idx_step;

    assign go_n         = (char_len_i == '0) ? N_MAX : N_W'(char_len_i);
    assign go_first_idx = lsb_i ? '0 : IDX_W'(go_n - N_W'(1));

    assign two_n      = {1'b0, n_reg} << 1;
    assign tick       = (state_reg == ST_SHIFT) && (div_cnt_reg == div_reg);
    assign rise_tick  = tick && !sclk_reg;
    assign fall_tick  = tick && sclk_reg;
    assign first_rise = rise_tick && (edge_cnt_reg == '0);
    // The Nth falling edge is the final SCLK toggle of the transfer.
    assign last_tick  = fall_tick && (edge_cnt_reg == (two_n - CNT_W'(1)));

    // Falling-edge launch skips the final edge; rising-edge launch skips the
    // first edge so the first bit (driven at go) is valid across its sample.
    assign tx_adv = tx_neg_reg ? (fall_tick && !last_tick)
                               : (rise_tick && !first_rise);
    assign sample = rx_neg_reg ? fall_tick : rise_tick;

    assign mosi_bit    = tx_reg[tx_idx_reg];
    assign tx_idx_step = lsb_reg ? (tx_idx_reg + IDX_W'(1)) : (tx_idx_reg - IDX_W'(1));
    assign rx_idx_step = lsb_reg ? (rx_idx_reg + IDX_W'(1)) : (rx_idx_reg - IDX_W'(1));

`ifdef SPI_MASTER_LOOPBACK_EN
    logic loop_reg;
    assign rx_in = loop_reg ? mosi_bit : miso_pad_i;
`else
    assign rx_in = miso_pad_i;
`endif

    // Received bits are written directly at their final position, so the
    // untouched bits N..DATA_W-1 keep the zero loaded at the go cycle.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rx_bit
            assign rx_shift_next[gi] = (sample && (rx_idx_reg == IDX_W'(gi)))
                                       ? rx_in : rx_shift_reg[gi];
        end
    endgenerate

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (go_i) state_next = ST_SHIFT;
            ST_SHIFT: if (last_tick) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = 1'b0;
        done_o     = 1'b0;
        ss_pad_o   = '1;
        mosi_pad_o = 1'b0;
        case (state_reg)
            ST_SHIFT: begin
                busy_o     = 1'b1;
                ss_pad_o   = ~ss_sel_reg;
                mosi_pad_o = mosi_bit;
            end
            ST_DONE: begin
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign sclk_pad_o = sclk_reg;
    assign rx_data_o  = rx_data_reg;

    // ------------------------------------------------------------ datapath
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tx_reg       <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            n_reg        <= '0;
            div_reg      <= '0;
            lsb_reg      <= 1'b0;
            tx_neg_reg   <= 1'b0;
            rx_neg_reg   <= 1'b0;
            ss_sel_reg   <= '0;
            div_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
            sclk_reg     <= 1'b0;
            tx_idx_reg   <= '0;
            rx_idx_reg   <= '0;
`ifdef SPI_MASTER_LOOPBACK_EN
            loop_reg     <= 1'b0;
`endif
        end else if ((state_reg == ST_IDLE) && go_i) begin
            tx_reg       <= tx_data_i;
            rx_shift_reg <= '0;
            n_reg        <= go_n;
            div_reg      <= divider_i;
            lsb_reg      <= lsb_i;
            tx_neg_reg   <= tx_negedge_i;
            rx_neg_reg   <= rx_negedge_i;
            ss_sel_reg   <= ss_sel_i;
            div_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
            sclk_reg     <= 1'b0;
            tx_idx_reg   <= go_first_idx;
            rx_idx_reg   <= go_first_idx;
`ifdef SPI_MASTER_LOOPBACK_EN
            loop_reg     <= loop_i;
`endif
        end else if (state_reg == ST_SHIFT) begin
            if (tick) begin
                div_cnt_reg  <= '0;
                sclk_reg     <= ~sclk_reg;
                edge_cnt_reg <= edge_cnt_reg + CNT_W'(1);
            end else begin
                div_cnt_reg  <= div_cnt_reg + DIV_W'(1);
            end
            if (tx_adv) begin
                tx_idx_reg <= tx_idx_step;
            end
            if (sample) begin
                rx_idx_reg <= rx_idx_step;
            end
            rx_shift_reg <= rx_shift_next;
            // Include a sample taken on the final edge itself.
            if (last_tick) begin
                rx_data_reg <= rx_shift_next;
            end
        end
    end

endmodule
